mem_fetch_sequencer: RTL
========================

// Module: mem_fetch_sequencer
// PURPOSE
//  Read-address generator that sits directly upstream of main_memory_32k_x_32bit. Produces one read per cycle.
//  Each read delivers x[i] plus the weight w_k[i] of 10 parallel neuron lanes.
//  Per layer pass: one bias fetch, then IN_SIZE input/weight fetches.
//  Emits strobes aligned with the memory's registered read data, so the downstream MAC bank knows when data is valid.
// PARAMETERS
//  IN_SIZE  784   input vector length (1..8192); weights per neuron
//  W_BASE   0     word address of w_1[0]; lane k weights at W_BASE+(k-1)*IN_SIZE+i (row-major)
//  B_BASE   7840  word address of b_1; lane k bias at B_BASE+(k-1)
//  X_BASE   7850  word address of x[0]
// PORTS
//  clock_mem     in   1   single clock; all state on rising edge
//  rst           in   1   reset, asynchronous assert, active-low
//  start         in   1   pulse: begin one layer pass (accepted only in IDLE)
//  mac_ready     in   1   downstream can accept a data beat this cycle+1
//  rd_en         out  1   memory read strobe (combinational from state/mac_ready)
//  x_addr        out  16  X_BASE+i
//  w1_addr..w10_addr out 16 each  W_BASE+(k-1)*IN_SIZE+i
//  b1_addr..b10_addr out 16 each  B_BASE+(k-1), constant
//  bias_valid    out  1   registered; b*_data valid this cycle
//  data_valid    out  1   registered; x_data/w*_data valid this cycle
//  data_last     out  1   registered; qualifies data_valid beat for i==IN_SIZE-1
//  busy          out  1   state != IDLE; top-level must hold memory wr_en low while set
//  done          out  1   one-cycle pulse at end of pass
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, i=0, bias_valid=data_valid=data_last=done=0, rd_en=0, busy=0.
//   During reset, x_addr=X_BASE and wk_addr=W_BASE+(k-1)*IN_SIZE.
//  Counter i: 13 bits, 0..IN_SIZE-1. Addresses = base + i, computed as 16-bit sums; bases are elaboration constants.
//  FSM states: IDLE -> BIAS -> FETCH -> DRAIN -> DONE -> IDLE.
//  IDLE:  rd_en=0. When start=1, go to BIAS and clear i to 0.
//  BIAS:  rd_en=1 unconditionally, for exactly one cycle. Next state is FETCH.
//  FETCH: issue = mac_ready; rd_en = issue.
//   On an issue cycle: i++. If i==IN_SIZE-1, go to DRAIN with i cleared to 0.
//   mac_ready=0 stalls: no rd_en, i and addresses held. The memory holds its last outputs.
//  DRAIN: rd_en=0, lasts one cycle; lets the final beat appear. Next state is DONE.
//  DONE:  done=1 for one cycle, then IDLE.
//  Strobes (memory latency = 1 cycle):
//   bias_valid <= (state==BIAS)
//   data_valid <= (state==FETCH && issue)
//   data_last  <= (state==FETCH && issue && i==IN_SIZE-1)
//  Latency with mac_ready held 1:
//   start sampled at edge E0; bias_valid high after E1.
//   First data_valid high after E2; data_last after E(IN_SIZE+1).
//   done high after E(IN_SIZE+3).
//  Edge cases:
//   start while busy is ignored.
//   start during the DONE cycle is ignored; it must be reissued in IDLE.
//   IN_SIZE==1: FETCH lasts one issue; data_valid and data_last assert on the same beat.
//   mac_ready drops on the last beat: DRAIN is entered only after the last beat is issued.
//   Reset mid-pass aborts immediately, with no done pulse. Downstream must treat rst as abort.
//  No write path: the module never drives wr_en or wr_data.
// STRUCTURE
//  Shared package nn_accel_pkg holds:
//   ADDR_W=16, DATA_W=32, NUM_LANES=10
//   IN_SIZE, W_BASE, B_BASE, X_BASE memory-map constants
//   FSM state encoding
//  The memory hex loader must use the same memory-map constants.
//  Single module, no sub-modules. The 10 lane address adders come from a generate loop.
// TESTING (bench instantiates this block + main_memory_32k_x_32bit with a known hex image)
//  1. IN_SIZE=784, mac_ready=1, start pulse:
//     - bias_valid once, with b1_data..b10_data = mem[7840..7849]
//     - 784 data_valid beats; beat i has x_data=mem[7850+i] and w3_data=mem[1568+i]
//     - data_last only on beat 783; done exactly 787 cycles after start
//  2. Stall: mac_ready toggled 1,0,0,1 pseudo-randomly:
//     - beat count stays 784, with no skipped or duplicated i
//     - addresses frozen while mac_ready=0
//  3. start pulsed during FETCH and in DONE cycle -> ignored, no second pass.
//     start in IDLE afterwards -> new pass.
//  4. rst=0 asserted mid-FETCH (i=300):
//     - same cycle: all strobes 0, busy=0
//     - next start replays from i=0
//  5. IN_SIZE=1 instance -> one beat with data_valid=data_last=1; done 4 cycles after start.
//  6. Address check: with i=783, w10_addr=W_BASE+9*784+783=7839; x_addr=8633.

Source files
------------

// File: rtl/nn_accel_pkg.sv
// ============================================================================
// Module : nn_accel_pkg
// Brief  : Shared widths, memory-map constants and fetch FSM encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package nn_accel_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int NUM_LANES = 10;
  localparam int CNT_W     = 13;

  // Memory map; the hex image loader must use these same constants.
  localparam int IN_SIZE = 784;
  localparam int W_BASE  = 0;
  localparam int B_BASE  = 7840;
  localparam int X_BASE  = 7850;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BIAS  = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_fetch_sequencer.sv
// ============================================================================
// Module : mem_fetch_sequencer
// Brief  : Read-address generator for one layer pass (bias, then IN_SIZE beats).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_fetch_sequencer
  import nn_accel_pkg::*;
#(
  parameter int IN_SIZE = nn_accel_pkg::IN_SIZE,
  parameter int W_BASE  = nn_accel_pkg::W_BASE,
  parameter int B_BASE  = nn_accel_pkg::B_BASE,
  parameter int X_BASE  = nn_accel_pkg::X_BASE
) (
  input  logic              clock_mem,
  input  logic              rst,
  input  logic              start,
  input  logic              mac_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] w1_addr,
  output logic [ADDR_W-1:0] w2_addr,
  output logic [ADDR_W-1:0] w3_addr,
  output logic [ADDR_W-1:0] w4_addr,
  output logic [ADDR_W-1:0] w5_addr,
  output logic [ADDR_W-1:0] w6_addr,
  output logic [ADDR_W-1:0] w7_addr,
  output logic [ADDR_W-1:0] w8_addr,
  output logic [ADDR_W-1:0] w9_addr,
  output logic [ADDR_W-1:0] w10_addr,
  output logic [ADDR_W-1:0] b1_addr,
  output logic [ADDR_W-1:0] b2_addr,
  output logic [ADDR_W-1:0] b3_addr,
  output logic [ADDR_W-1:0] b4_addr,
  output logic [ADDR_W-1:0] b5_addr,
  output logic [ADDR_W-1:0] b6_addr,
  output logic [ADDR_W-1:0] b7_addr,
  output logic [ADDR_W-1:0] b8_addr,
  output logic [ADDR_W-1:0] b9_addr,
  output logic [ADDR_W-1:0] b10_addr,
  output logic              bias_valid,
  output logic              data_valid,
  output logic              data_last,
  output logic              busy,
  output logic              done
);

  localparam int c_LAST = IN_SIZE - 1;

  state_t             r_state;
  logic [CNT_W-1:0]   r_i;
  logic               r_bias_valid;
  logic               r_data_valid;
  logic               r_data_last;
  logic               r_done;

  logic               w_issue;
  logic               w_at_last;
  logic [ADDR_W-1:0]  w_w_addr [NUM_LANES];
  logic [ADDR_W-1:0]  w_b_addr [NUM_LANES];

  assign w_issue   = (r_state == ST_FETCH) && mac_ready;
  assign w_at_last = (r_i == CNT_W'(c_LAST));

  assign rd_en  = (r_state == ST_BIAS) || w_issue;
  assign busy   = (r_state != ST_IDLE);
  assign x_addr = ADDR_W'(X_BASE) + ADDR_W'(r_i);

  // Lane bases fold to constants; only the +i adder is real logic.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [ADDR_W-1:0] c_W_LANE = ADDR_W'(W_BASE + k * IN_SIZE);
    localparam logic [ADDR_W-1:0] c_B_LANE = ADDR_W'(B_BASE + k);
    assign w_w_addr[k] = c_W_LANE + ADDR_W'(r_i);
    assign w_b_addr[k] = c_B_LANE;
  end

  // Strobes are delayed one cycle to line up with the memory's registered read data.
  always_ff @(posedge clock_mem or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_i          <= '0;
      r_bias_valid <= 1'b0;
      r_data_valid <= 1'b0;
      r_data_last  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_bias_valid <= (r_state == ST_BIAS);
      r_data_valid <= w_issue;
      r_data_last  <= w_issue && w_at_last;
      r_done       <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_BIAS;
            r_i     <= '0;
          end
        end
        ST_BIAS:  r_state <= ST_FETCH;
        ST_FETCH: begin
          if (w_issue) begin
            if (w_at_last) begin
              r_state <= ST_DRAIN;
              r_i     <= '0;
            end else begin
              r_i <= r_i + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign bias_valid = r_bias_valid;
  assign data_valid = r_data_valid;
  assign data_last  = r_data_last;
  assign done       = r_done;

  assign w1_addr  = w_w_addr[0];
  assign w2_addr  = w_w_addr[1];
  assign w3_addr  = w_w_addr[2];
  assign w4_addr  = w_w_addr[3];
  assign w5_addr  = w_w_addr[4];
  assign w6_addr  = w_w_addr[5];
  assign w7_addr  = w_w_addr[6];
  assign w8_addr  = w_w_addr[7];
  assign w9_addr  = w_w_addr[8];
  assign w10_addr = w_w_addr[9];

  assign b1_addr  = w_b_addr[0];
  assign b2_addr  = w_b_addr[1];
  assign b3_addr  = w_b_addr[2];
  assign b4_addr  = w_b_addr[3];
  assign b5_addr  = w_b_addr[4];
  assign b6_addr  = w_b_addr[5];
  assign b7_addr  = w_b_addr[6];
  assign b8_addr  = w_b_addr[7];
  assign b9_addr  = w_b_addr[8];
  assign b10_addr = w_b_addr[9];

endmodule

`default_nettype wire
